// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and Booth pair codes for booth_mult_seq
package booth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARITH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } booth_state_t;

  // {Q[0], q_1} values that call for an add or a subtract of M
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/booth_ctrl_fsm.sv
// rtl/booth_ctrl_fsm.sv - control FSM and iteration counter for the radix-2 Booth multiplier
module booth_ctrl_fsm
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q_0,
  input  logic q_1,
  output logic load,
  output logic add,
  output logic sub,
  output logic shift,
  output logic decr,
  output logic done,
  output logic busy,
  output logic last_shift
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  booth_state_t     state_q;
  booth_state_t     state_d;
  logic [CNT_W-1:0] count_q;

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration counter: loaded with WIDTH, stepped down once per shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_INIT;
    end else if (decr) begin
      count_q <= count_q - CNT_ONE;
    end
  end

  // Next-state logic; start only matters in IDLE, and every operation takes the same path length
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ARITH;
      ST_ARITH: state_d = ST_SHIFT;
      ST_SHIFT: state_d = (count_q == CNT_ONE) ? ST_DONE : ST_ARITH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore decode of the strobes from state and the current Booth pair
  always_comb begin
    load       = 1'b0;
    add        = 1'b0;
    sub        = 1'b0;
    shift      = 1'b0;
    decr       = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    last_shift = 1'b0;
    case (state_q)
      ST_LOAD:  load = 1'b1;
      ST_ARITH: begin
        add = ({q_0, q_1} == PAIR_ADD);
        sub = ({q_0, q_1} == PAIR_SUB);
      end
      ST_SHIFT: begin
        shift      = 1'b1;
        decr       = 1'b1;
        last_shift = (count_q == CNT_ONE);
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with start/busy/done handshake
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 load,
  output logic                 add,
  output logic                 sub,
  output logic                 shift,
  output logic                 decr
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // A and M carry one guard bit so that -M is exact for M = -2^(WIDTH-1)
  logic [WIDTH:0]       m_q;
  logic [WIDTH:0]       a_q;
  logic [WIDTH-1:0]     q_opnd;
  logic [WIDTH-1:0]     q_q;
  logic                 q_1_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 last_shift;
  logic                 accept;

  assign accept  = start && !busy;
  assign product = product_q;

  booth_ctrl_fsm #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .q_0        (q_q[0]),
    .q_1        (q_1_q),
    .load       (load),
    .add        (add),
    .sub        (sub),
    .shift      (shift),
    .decr       (decr),
    .done       (done),
    .busy       (busy),
    .last_shift (last_shift)
  );

  // Operand capture on the accepting edge; inputs may change freely afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      q_opnd <= '0;
    end else if (accept) begin
      m_q    <= {multiplicand[WIDTH-1], multiplicand};
      q_opnd <= multiplier;
    end
  end

  // Booth datapath: load, add/subtract M into A, then arithmetic right shift of {A,Q,q_1}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      q_1_q <= 1'b0;
    end else if (load) begin
      a_q   <= '0;
      q_q   <= q_opnd;
      q_1_q <= 1'b0;
    end else if (add) begin
      a_q <= a_q + m_q;
    end else if (sub) begin
      a_q <= a_q - m_q;
    end else if (shift) begin
      a_q   <= {a_q[WIDTH], a_q[WIDTH:1]};
      q_q   <= {a_q[0], q_q[WIDTH-1:1]};
      q_1_q <= q_q[0];
    end
  end

  // Product captured from the post-shift value on the final shift, so it is valid alongside done;
  // {A_shifted[WIDTH-1:0], Q_shifted} is exactly {A, Q[WIDTH-1:1]} before the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
    end else if (last_shift) begin
      product_q <= {a_q, q_q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq with a behavioural model
module tb_booth_mult_seq;

  localparam int TW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy, done, load, add, sub, shift, decr;
  logic [15:0] product;

  logic        start4;
  logic [3:0]  mcand4;
  logic [3:0]  mplier4;
  logic        busy4, done4, load4, add4, sub4, shift4, decr4;
  logic [7:0]  product4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .load         (load),
    .add          (add),
    .sub          (sub),
    .shift        (shift),
    .decr         (decr)
  );

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
    .multiplicand (mcand4),
    .multiplier   (mplier4),
    .busy         (busy4),
    .done         (done4),
    .product      (product4),
    .load         (load4),
    .add          (add4),
    .sub          (sub4),
    .shift        (shift4),
    .decr         (decr4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: ph counts edges since the accepting edge (-1 = idle)
  int          ph = -1;
  logic [7:0]  om = '0;
  logic [7:0]  oq = '0;
  logic [15:0] eprod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    = -1;
      eprod = '0;
    end else if (ph < 0) begin
      if (start) begin
        ph = 0;
        om = mcand;
        oq = mplier;
      end
    end else if (ph == 2*TW+1) begin
      ph = -1;
    end else begin
      ph++;
      if (ph == 2*TW+1) eprod = 16'(int'($signed(om)) * int'($signed(oq)));
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit         e_arith, e_shift;
    logic [1:0] pair;
    int         i;
    e_arith = (ph >= 1) && (ph <= 2*TW) && (ph % 2 == 1);
    e_shift = (ph >= 2) && (ph <= 2*TW) && (ph % 2 == 0);
    pair    = 2'b00;
    if (e_arith) begin
      i    = (ph - 1) / 2;
      pair = {oq[i], (i == 0) ? 1'b0 : oq[i-1]};
    end
    chk("busy",    busy,    (ph >= 0));
    chk("done",    done,    (ph == 2*TW+1));
    chk("product", product, eprod);
    chk("load",    load,    (ph == 0));
    chk("add",     add,     e_arith && (pair == 2'b01));
    chk("sub",     sub,     e_arith && (pair == 2'b10));
    chk("shift",   shift,   e_shift);
    chk("decr",    decr,    e_shift);
  end

  int          c_load, c_add, c_sub, c_shift, c_decr;
  logic [15:0] seq;

  task automatic sample8();
    if (load)  c_load++;
    if (add)   begin c_add++; seq = {seq[14:0], 1'b0}; end
    if (sub)   begin c_sub++; seq = {seq[14:0], 1'b1}; end
    if (shift) c_shift++;
    if (decr)  c_decr++;
  endtask

  // Runs one WIDTH=8 operation from an idle DUT; optional start poke mid-operation
  task automatic run8(input logic [7:0] m, input logic [7:0] q, input int poke_at, output int lat);
    start = 1'b1; mcand = m; mplier = q;
    @(posedge clk); #1;
    start = 1'b0; mcand = 8'($urandom); mplier = 8'($urandom);
    c_load = 0; c_add = 0; c_sub = 0; c_shift = 0; c_decr = 0; seq = '0;
    lat = 0;
    sample8();
    while (!done && lat < 100) begin
      if (lat == poke_at) begin start = 1'b1; mcand = ~m; mplier = q + 8'd1; end
      else if (lat == poke_at + 1) start = 1'b0;
      @(posedge clk); #1;
      lat++;
      sample8();
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    rst_n = 1'b0; start = 1'b1; mcand = 8'h11; mplier = 8'h22;
    start4 = 1'b0; mcand4 = '0; mplier4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_strobes", {load, add, sub, shift, decr}, 0);
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_release", busy, 0);

    run8(8'd3, 8'hFC, -1, lat);
    chk("lat_3x-4", lat, 17);
    chk("prod_3x-4", product, 16'hFFF4);
    chk("idle_after_done", busy, 0);

    run8(8'h80, 8'h80, -1, lat);
    chk("prod_min_min", product, 16'h4000);
    run8(8'h80, 8'h7F, -1, lat);
    chk("prod_min_max", product, 16'hC080);
    run8(8'h00, 8'hFF, -1, lat);
    chk("prod_0_m1", product, 16'h0000);

    run8(8'd5, 8'h55, -1, lat);
    chk("strb_load", c_load, 1);
    chk("strb_shift", c_shift, 8);
    chk("strb_decr", c_decr, 8);
    chk("strb_add", c_add, 4);
    chk("strb_sub", c_sub, 4);
    chk("strb_seq", seq[7:0], 8'hAA);
    chk("prod_5x55", product, 16'h01A9);

    run8(8'd7, 8'd9, 4, lat);
    chk("poke_lat", lat, 17);
    chk("poke_prod", product, 16'h003F);

    start = 1'b1; mcand = 8'd6; mplier = 8'hF9;
    @(posedge clk); #1;
    mcand = 8'hF6; mplier = 8'h0B;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_lat", n, 17);
    chk("hold_prod1", product, 16'hFFD6);
    @(posedge clk); #1;
    chk("hold_idle_gap", busy, 0);
    @(posedge clk); #1;
    chk("hold_accept_load", load, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_lat2", n, 17);
    chk("hold_prod2", product, 16'hFF92);
    @(posedge clk); #1;

    start = 1'b1; mcand = 8'd9; mplier = 8'hEB;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 7) begin @(posedge clk); #1; n++; end
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    chk("midrst_strobes", {load, add, sub, shift, decr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {busy, done}, 0);
    end
    run8(8'd9, 8'hEB, -1, lat);
    chk("after_rst_lat", lat, 17);
    chk("after_rst_prod", product, 16'hFF43);

    start4 = 1'b1; mcand4 = 4'd7; mplier4 = 4'h8;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("w4_lat", n, 9);
    chk("w4_prod_7x-8", product4, 8'hC8);
    @(posedge clk); #1;
    start4 = 1'b1; mcand4 = 4'd3; mplier4 = 4'hC;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("w4_lat2", n, 9);
    chk("w4_prod_3x-4", product4, 8'hF4);
    @(posedge clk); #1;

    for (int k = 0; k < 1500; k++) begin
      start  = ($urandom_range(0, 3) == 0);
      mcand  = pick();
      mplier = pick();
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
